// File: rtl/life_keys_pkg.sv
// Shared key codes, button indices and the priority encoder helpers for life_keys.
package life_keys_pkg;

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_FLIP  = 3'd5;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FLIP  = 4;
  localparam int NUM_BTN   = 5;

  // One-hot of the winning request: flip > up > down > left > right.
  function automatic logic [4:0] pick_winner(input logic [4:0] req);
    logic [4:0] win;
    if (req[BTN_FLIP]) begin
      win = 5'b10000;
    end else if (req[BTN_UP]) begin
      win = 5'b00001;
    end else if (req[BTN_DOWN]) begin
      win = 5'b00010;
    end else if (req[BTN_LEFT]) begin
      win = 5'b00100;
    end else if (req[BTN_RIGHT]) begin
      win = 5'b01000;
    end else begin
      win = 5'b00000;
    end
    return win;
  endfunction

  // Key code for a one-hot winner; anything else maps to KEY_NONE.
  function automatic logic [2:0] winner_code(input logic [4:0] win);
    logic [2:0] code;
    case (win)
      5'b00001: code = KEY_UP;
      5'b00010: code = KEY_DOWN;
      5'b00100: code = KEY_LEFT;
      5'b01000: code = KEY_RIGHT;
      5'b10000: code = KEY_FLIP;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/life_keys_debounce.sv
// One button: 2-flop synchroniser, debouncer, registered press/repeat event pulse.
module life_debounce #(
  parameter int unsigned DEBOUNCE      = 10,
  parameter int unsigned DEB_W         = 20,
  parameter int unsigned REPEAT_DELAY  = 12_000_000,
  parameter int unsigned REPEAT_PERIOD = 3_000_000,
  parameter int unsigned REP_W         = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic rep_en,
  output logic event_o
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             event_q, event_d;
  logic             press_s;
  logic             fire_s;
  logic [REP_W-1:0] rep_limit_s;

  // Next-state: synchroniser shift, debounce counting, repeat timing.
  always_comb begin
    sync1_d     = btn_i;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    deb_cnt_d   = deb_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    fire_s      = 1'b0;

    // Accept the new level once it has differed for DEBOUNCE consecutive cycles.
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE - 1)) begin
        stable_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_d = '0;
    end

    press_s     = stable_d & ~stable_q;
    rep_limit_s = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);

    // Counter value 0 means idle; the press loads 1 so it reaches the limit
    // exactly REPEAT_DELAY cycles after the press pulse.
    if (press_s) begin
      rep_cnt_d   = rep_en ? REP_W'(1) : '0;
      rep_first_d = 1'b1;
    end else if (!rep_en || !stable_d || (rep_cnt_q == '0)) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == rep_limit_s) begin
      fire_s      = 1'b1;
      rep_cnt_d   = REP_W'(1);
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end

    event_d = press_s | fire_s;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      event_q     <= event_d;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/life_keys.sv
// Key encoder: five debounced buttons -> pending set -> one key code per cycle.
module life_keys
  import life_keys_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 10,
  parameter int unsigned DEB_W         = 20,
  parameter int unsigned REPEAT_DELAY  = 12_000_000,
  parameter int unsigned REPEAT_PERIOD = 3_000_000,
  parameter int unsigned REP_W         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn,
  input  logic       rep_en,
  output logic [2:0] keys
);

  logic [4:0] evt_s;
  logic [4:0] req_s;
  logic [4:0] win_s;
  logic [4:0] pending_q, pending_d;
  logic [2:0] keys_q, keys_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    // Flip never auto-repeats, so its repeat enable is tied low.
    life_debounce #(
      .DEBOUNCE      (DEBOUNCE),
      .DEB_W         (DEB_W),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REP_W         (REP_W)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn[i]),
      .rep_en  ((i == BTN_FLIP) ? 1'b0 : rep_en),
      .event_o (evt_s[i])
    );
  end

  // Serve the highest-priority request; the rest stay pending.
  always_comb begin
    req_s     = pending_q | evt_s;
    win_s     = pick_winner(req_s);
    keys_d    = winner_code(win_s);
    pending_d = req_s & ~win_s;
  end

  // Pending set and registered key output.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 5'b00000;
      keys_q    <= KEY_NONE;
    end else begin
      pending_q <= pending_d;
      keys_q    <= keys_d;
    end
  end

  assign keys = keys_q;

endmodule

// File: tb/tb_life_keys.sv
// Scoreboard bench for life_keys with DEBOUNCE=4, REPEAT_DELAY=16, REPEAT_PERIOD=8.
module tb_life_keys;
  import life_keys_pkg::*;

  localparam int LAT = 6;  // first sampling edge -> code visible

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] btn;
  logic       rep_en;
  logic [2:0] keys;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   e0;

  life_keys #(
    .DEBOUNCE      (4),
    .DEB_W         (20),
    .REPEAT_DELAY  (16),
    .REPEAT_PERIOD (8),
    .REP_W         (24)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .rep_en (rep_en),
    .keys   (keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic push_exp(input int c, input logic [2:0] code);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every cycle keys must be either the scheduled code or KEY_NONE.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        check_val("key", 32'(keys), 32'(mon_e.code));
      end else begin
        check_val("idle", 32'(keys), 32'(KEY_NONE));
      end
    end
  end

  initial begin
    reset  = 1'b1;
    btn    = 5'b00000;
    rep_en = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);

    // 1: single up press, one code only
    e0  = cyc + 1;
    btn = 5'b00001;
    push_exp(e0 + LAT, KEY_UP);
    idle(10);
    btn = 5'b00000;
    idle(20);
    check_val("t1_left", 32'(exp_q.size()), 32'd0);

    // 2: bounce shorter than DEBOUNCE yields nothing
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 5'b00100 : 5'b00000;
      idle(2);
    end
    btn = 5'b00000;
    idle(20);

    // 3: held down with auto-repeat
    rep_en = 1'b1;
    e0  = cyc + 1;
    btn = 5'b00010;
    push_exp(e0 + LAT, KEY_DOWN);
    for (int k = 0; k < 6; k++) push_exp(e0 + LAT + 16 + 8 * k, KEY_DOWN);
    idle(60);
    btn = 5'b00000;
    idle(30);
    rep_en = 1'b0;
    check_val("t3_left", 32'(exp_q.size()), 32'd0);

    // 4: held flip never repeats
    rep_en = 1'b1;
    e0  = cyc + 1;
    btn = 5'b10000;
    push_exp(e0 + LAT, KEY_FLIP);
    idle(60);
    btn = 5'b00000;
    idle(30);
    rep_en = 1'b0;
    check_val("t4_left", 32'(exp_q.size()), 32'd0);

    // 5: simultaneous presses served in priority order
    e0  = cyc + 1;
    btn = 5'b11001;
    push_exp(e0 + LAT,     KEY_FLIP);
    push_exp(e0 + LAT + 1, KEY_UP);
    push_exp(e0 + LAT + 2, KEY_RIGHT);
    idle(10);
    btn = 5'b00000;
    idle(20);
    check_val("t5_left", 32'(exp_q.size()), 32'd0);

    // 6: reset between stable rise and output discards the press
    e0  = cyc + 1;
    btn = 5'b00010;
    idle(6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push_exp(cyc + 1 + LAT, KEY_DOWN);
    idle(12);
    btn = 5'b00000;
    idle(20);
    check_val("t6_left", 32'(exp_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
